auto_cg_reg_bank: RTL and testbench

//   Multi-channel enable register bank with automatic clock-gating control.

---
 rtl/auto_cg_reg_bank.sv | 115 +++++++++++
 tb/tb_auto_cg_reg_bank.sv | 133 +++++++++++++
 2 files changed

// File: rtl/auto_cg_reg_bank.sv
// Multi-channel enable register bank. Each channel has an idle-driven clock-gate FSM
// (ACTIVE/GATED/WAKE) with a RDY handshake, and the bank keeps an all-gated cycle counter.
module auto_cg_reg_bank #(
  parameter int WIDTH       = 8,
  parameter int NCH         = 4,
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCH*WIDTH-1:0] D_IN,
  input  logic [NCH-1:0]       EN,
  output logic [NCH*WIDTH-1:0] D_OUT,
  output logic [NCH-1:0]       RDY,
  output logic [NCH-1:0]       GATED,
  output logic [NCH-1:0]       GCLK_EN,
  output logic [CNT_W-1:0]     ALL_GATED_CNT
);

  localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);
  localparam bit GATING_EN = (IDLE_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_GATED  = 2'd1,
    ST_WAKE   = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] cnt_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    state_e            state_q, state_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [WAKE_W-1:0] wake_q, wake_d;
    logic [WIDTH-1:0]  data_q;
    logic              rdy_k, gated_k;

    always_ff @(posedge CLK) begin
      if (RST) begin
        state_q <= ST_ACTIVE;
        idle_q  <= '0;
        wake_q  <= '0;
        data_q  <= '0;
      end else begin
        state_q <= state_d;
        idle_q  <= idle_d;
        wake_q  <= wake_d;
        if (EN[k] && rdy_k) data_q <= D_IN[k*WIDTH +: WIDTH];
      end
    end

    // A load request in the idle-expiry cycle keeps the channel ACTIVE.
    always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      wake_d  = wake_q;
      case (state_q)
        ST_ACTIVE: begin
          if (EN[k]) begin
            idle_d = '0;
          end else if (GATING_EN) begin
            if (idle_q == IDLE_LAST) begin
              state_d = ST_GATED;
              idle_d  = '0;
            end else begin
              idle_d = idle_q + 1'b1;
            end
          end
        end
        ST_GATED: begin
          if (EN[k]) begin
            state_d = ST_WAKE;
            wake_d  = '0;
          end
        end
        ST_WAKE: begin
          if (wake_q == WAKE_LAST) begin
            state_d = ST_ACTIVE;
            idle_d  = '0;
            wake_d  = '0;
          end else begin
            wake_d = wake_q + 1'b1;
          end
        end
        default: state_d = ST_ACTIVE;
      endcase
    end

    always_comb begin
      rdy_k   = (state_q == ST_ACTIVE);
      gated_k = (state_q == ST_GATED);
    end

    assign RDY[k]                   = rdy_k;
    assign GATED[k]                 = gated_k;
    assign GCLK_EN[k]               = EN[k] & rdy_k;
    assign D_OUT[k*WIDTH +: WIDTH]  = data_q;
  end

  always_ff @(posedge CLK) begin
    if (RST)         cnt_q <= '0;
    else if (&GATED) cnt_q <= sat_inc(cnt_q);
  end

  assign ALL_GATED_CNT = cnt_q;

endmodule

// File: tb/tb_auto_cg_reg_bank.sv
// Directed bench for auto_cg_reg_bank: reset, transfer, idle gating, wake handshake,
// idle-expiry race and the all-gated counter (including a narrow saturating copy).
module tb_auto_cg_reg_bank;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d_in;
  logic [3:0]  en;
  logic [31:0] d_out, s_d_out;
  logic [3:0]  rdy, gated, gclk_en, s_rdy, s_gated, s_gclk_en;
  logic [15:0] cnt;
  logic [1:0]  s_cnt;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  auto_cg_reg_bank #(.WIDTH(8), .NCH(4), .IDLE_CYCLES(4), .WAKE_CYCLES(2), .CNT_W(16)) u_dut (
    .CLK(clk), .RST(rst), .D_IN(d_in), .EN(en), .D_OUT(d_out), .RDY(rdy),
    .GATED(gated), .GCLK_EN(gclk_en), .ALL_GATED_CNT(cnt));

  auto_cg_reg_bank #(.WIDTH(8), .NCH(4), .IDLE_CYCLES(4), .WAKE_CYCLES(2), .CNT_W(2)) u_sat (
    .CLK(clk), .RST(rst), .D_IN(d_in), .EN(en), .D_OUT(s_d_out), .RDY(s_rdy),
    .GATED(s_gated), .GCLK_EN(s_gclk_en), .ALL_GATED_CNT(s_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 4'h0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 4'h0; d_in = 32'hFFFF_FFFF;
    tick(); tick();
    n_cmp++; if (d_out !== 32'h0) begin n_bad++; $display("FAIL rst_dout: got %h want %h", d_out, 32'h0); end
    n_cmp++; if (rdy !== 4'hF) begin n_bad++; $display("FAIL rst_rdy: got %h want %h", rdy, 4'hF); end
    n_cmp++; if (gated !== 4'h0) begin n_bad++; $display("FAIL rst_gated: got %h want %h", gated, 4'h0); end
    n_cmp++; if (cnt !== 16'h0) begin n_bad++; $display("FAIL rst_cnt: got %h want %h", cnt, 16'h0); end
    n_cmp++; if (gclk_en !== 4'h0) begin n_bad++; $display("FAIL rst_gclk: got %h want %h", gclk_en, 4'h0); end
    rst = 1'b0;
  endtask

  task automatic test_transfer();
    do_reset();
    d_in = 32'h3322_11A5; en = 4'b0001;
    #1;
    n_cmp++; if (gclk_en !== 4'b0001) begin n_bad++; $display("FAIL xfer_gclk: got %b want %b", gclk_en, 4'b0001); end
    tick();
    n_cmp++; if (d_out !== 32'h0000_00A5) begin n_bad++; $display("FAIL xfer_load: got %h want %h", d_out, 32'h0000_00A5); end
    en = 4'b0000; d_in = 32'h3322_11FF;
    #1;
    n_cmp++; if (gclk_en !== 4'b0000) begin n_bad++; $display("FAIL xfer_gclk_off: got %b want %b", gclk_en, 4'b0000); end
    tick();
    n_cmp++; if (d_out !== 32'h0000_00A5) begin n_bad++; $display("FAIL xfer_hold: got %h want %h", d_out, 32'h0000_00A5); end
  endtask

  task automatic test_gate_wake();
    do_reset();
    en = 4'b0000; d_in = 32'h0000_7700;
    repeat (3) tick();
    n_cmp++; if ({gated[1], rdy[1]} !== 2'b01) begin n_bad++; $display("FAIL gate_early: got gated/rdy %b want %b", {gated[1], rdy[1]}, 2'b01); end
    tick();
    n_cmp++; if ({gated[1], rdy[1]} !== 2'b10) begin n_bad++; $display("FAIL gate_4th: got gated/rdy %b want %b", {gated[1], rdy[1]}, 2'b10); end
    n_cmp++; if (d_out !== 32'h0) begin n_bad++; $display("FAIL gate_dout: got %h want %h", d_out, 32'h0); end
    en = 4'b0010; d_in = 32'h0000_3C00;
    #1;
    n_cmp++; if (gclk_en !== 4'b0000) begin n_bad++; $display("FAIL wake_gclk0: got %b want %b", gclk_en, 4'b0000); end
    tick();
    n_cmp++; if (gated !== 4'b1101 || rdy !== 4'b0000) begin n_bad++; $display("FAIL wake_e1: got gated %b rdy %b want 1101 0000", gated, rdy); end
    n_cmp++; if (cnt !== 16'd1) begin n_bad++; $display("FAIL wake_cnt: got %0d want %0d", cnt, 1); end
    tick();
    n_cmp++; if (rdy[1] !== 1'b0) begin n_bad++; $display("FAIL wake_e2_rdy: got %b want %b", rdy[1], 1'b0); end
    tick();
    n_cmp++; if (rdy[1] !== 1'b1 || gclk_en[1] !== 1'b1) begin n_bad++; $display("FAIL wake_e3_rdy: got rdy %b gclk %b want 1 1", rdy[1], gclk_en[1]); end
    n_cmp++; if (d_out[15:8] !== 8'h00) begin n_bad++; $display("FAIL wake_noearly: got %h want %h", d_out[15:8], 8'h00); end
    tick();
    n_cmp++; if (d_out[15:8] !== 8'h3C) begin n_bad++; $display("FAIL wake_load: got %h want %h", d_out[15:8], 8'h3C); end
  endtask

  task automatic test_idle_race();
    do_reset();
    en = 4'b0000; d_in = 32'h0;
    repeat (3) tick();
    en = 4'b0100; d_in = 32'h005A_0000;
    tick();
    n_cmp++; if (d_out !== 32'h005A_0000) begin n_bad++; $display("FAIL race_load: got %h want %h", d_out, 32'h005A_0000); end
    n_cmp++; if (gated !== 4'b1011) begin n_bad++; $display("FAIL race_gated: got %b want %b", gated, 4'b1011); end
    n_cmp++; if (rdy !== 4'b0100) begin n_bad++; $display("FAIL race_rdy: got %b want %b", rdy, 4'b0100); end
    en = 4'b0000;
    tick();
    n_cmp++; if (rdy[2] !== 1'b1) begin n_bad++; $display("FAIL race_stay: got %b want %b", rdy[2], 1'b1); end
  endtask

  task automatic test_all_gated();
    do_reset();
    en = 4'hF; d_in = 32'hDEAD_BEEF;
    tick();
    n_cmp++; if (d_out !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL all_load: got %h want %h", d_out, 32'hDEAD_BEEF); end
    en = 4'h0;
    repeat (4) tick();
    n_cmp++; if (gated !== 4'hF || cnt !== 16'd0) begin n_bad++; $display("FAIL all_gate: got gated %h cnt %0d want F 0", gated, cnt); end
    repeat (3) tick();
    n_cmp++; if (cnt !== 16'd3) begin n_bad++; $display("FAIL all_cnt3: got %0d want %0d", cnt, 3); end
    n_cmp++; if (s_cnt !== 2'd3) begin n_bad++; $display("FAIL sat_cnt3: got %0d want %0d", s_cnt, 3); end
    en = 4'b0001;
    tick();
    n_cmp++; if (cnt !== 16'd4) begin n_bad++; $display("FAIL all_cnt4: got %0d want %0d", cnt, 4); end
    n_cmp++; if (s_cnt !== 2'd3) begin n_bad++; $display("FAIL sat_hold: got %0d want %0d", s_cnt, 3); end
    n_cmp++; if (gated !== 4'b1110 || rdy !== 4'b0000) begin n_bad++; $display("FAIL all_wake: got gated %b rdy %b want 1110 0000", gated, rdy); end
    tick();
    n_cmp++; if (cnt !== 16'd4 || rdy !== 4'b0000) begin n_bad++; $display("FAIL all_wake2: got cnt %0d rdy %b want 4 0000", cnt, rdy); end
    rst = 1'b1;
    tick();
    n_cmp++; if (rdy !== 4'hF || gated !== 4'h0) begin n_bad++; $display("FAIL wrst_state: got rdy %h gated %h want F 0", rdy, gated); end
    n_cmp++; if (d_out !== 32'h0 || cnt !== 16'd0 || s_cnt !== 2'd0) begin n_bad++; $display("FAIL wrst_data: got dout %h cnt %0d sat %0d want 0 0 0", d_out, cnt, s_cnt); end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 4'h0; d_in = 32'h0;
    test_reset();
    test_transfer();
    test_gate_wake();
    test_idle_race();
    test_all_gated();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
